// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: start detection, oversampling counters,
// checker/deserializer strobes and per-frame valid/error pulses.
module uart_rx_fsm #(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 5
) (
   input  logic                  clck,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  strt_glitch,
   input  logic                  par_err,
   input  logic                  stp_err,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  data_samp_en,
   output logic                  deser_en,
   output logic                  strt_chk_en,
   output logic                  par_chk_en,
   output logic                  stp_chk_en,
   output logic                  data_valid,
   output logic                  frame_err
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(8);

   state_t                state;
   state_t                state_nxt;
   logic [PRESCALE_W-1:0] p_lat;
   logic                  sticky;
   logic                  bit_end;
   logic                  frame_bad;

   assign bit_end   = (state != IDLE) && (edge_cnt == p_lat - 1'b1);
   assign frame_bad = stp_err | sticky;

   always_comb begin
      state_nxt    = state;
      data_samp_en = (state != IDLE);
      deser_en     = 1'b0;
      strt_chk_en  = 1'b0;
      par_chk_en   = 1'b0;
      stp_chk_en   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rx_in) state_nxt = START;
         end
         START: begin
            strt_chk_en = bit_end;
            if (bit_end) state_nxt = strt_glitch ? IDLE : DATA;
         end
         DATA: begin
            deser_en = bit_end;
            if (bit_end && bit_cnt == LAST_DATA)
               state_nxt = par_en ? PARITY : STOP;
         end
         PARITY: begin
            par_chk_en = bit_end;
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            stp_chk_en = bit_end;
            if (bit_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clck) begin
      if (rst) begin
         state      <= IDLE;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         p_lat      <= '0;
         sticky     <= 1'b0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         // Bit time is frozen at start detect so a mid-frame prescale change is harmless
         if (state == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            if (!rx_in) p_lat <= prescale;
         end else if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= (state_nxt == IDLE) ? '0 : bit_cnt + 1'b1;
         end else begin
            edge_cnt <= edge_cnt + 1'b1;
         end
         if (state == PARITY && bit_end) sticky <= sticky | par_err;
         if (state == STOP && bit_end) begin
            data_valid <= !frame_bad;
            frame_err  <= frame_bad;
            sticky     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: stimulus pushes expected strobe/pulse
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_rx_fsm;

   logic       clck;
   logic       rst;
   logic       rx_in;
   logic [5:0] prescale;
   logic       par_en;
   logic       strt_glitch;
   logic       par_err;
   logic       stp_err;
   logic [5:0] edge_cnt;
   logic [4:0] bit_cnt;
   logic       data_samp_en;
   logic       deser_en;
   logic       strt_chk_en;
   logic       par_chk_en;
   logic       stp_chk_en;
   logic       data_valid;
   logic       frame_err;

   uart_rx_fsm #(.PRESCALE_W(6), .BIT_CNT_W(5)) dut (
      .clck(clck),
      .rst(rst),
      .rx_in(rx_in),
      .prescale(prescale),
      .par_en(par_en),
      .strt_glitch(strt_glitch),
      .par_err(par_err),
      .stp_err(stp_err),
      .edge_cnt(edge_cnt),
      .bit_cnt(bit_cnt),
      .data_samp_en(data_samp_en),
      .deser_en(deser_en),
      .strt_chk_en(strt_chk_en),
      .par_chk_en(par_chk_en),
      .stp_chk_en(stp_chk_en),
      .data_valid(data_valid),
      .frame_err(frame_err)
   );

   // kinds: 0 strt_chk, 1 deser, 2 par_chk, 3 stp_chk, 4 data_valid, 5 frame_err
   typedef struct {
      int kind;
      int cyc;
      int bc;
   } ev_t;

   ev_t q[$];
   int  dv_cyc[$];
   int  cyc   = 0;
   int  tests = 0;
   int  fails = 0;

   initial begin
      clck = 1'b0;
      forever #5 clck = ~clck;
   end

   always @(posedge clck) cyc <= cyc + 1;

   task automatic chk(input int k);
      ev_t e;
      tests++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event kind=%0d cyc=%0d (required: none)", k, cyc);
      end else begin
         e = q.pop_front();
         if (e.kind != k || e.cyc != cyc || (k < 4 && e.bc != int'(bit_cnt))) begin
            fails++;
            $display("FAIL event got kind=%0d cyc=%0d bit_cnt=%0d, required kind=%0d cyc=%0d bit_cnt=%0d",
                     k, cyc, bit_cnt, e.kind, e.cyc, e.bc);
         end
      end
   endtask

   always @(negedge clck) begin
      if (!rst) begin
         if (data_valid && frame_err) begin
            tests++;
            fails++;
            $display("FAIL both_pulses cyc=%0d got dv=1 fe=1, required at most one", cyc);
         end
         if (strt_chk_en) chk(0);
         if (deser_en)    chk(1);
         if (par_chk_en)  chk(2);
         if (stp_chk_en)  chk(3);
         if (data_valid) begin
            chk(4);
            dv_cyc.push_back(cyc);
         end
         if (frame_err)   chk(5);
      end
   end

   task automatic direct(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic push(input int k, input int c, input int bc, input int lim);
      ev_t e;
      if (c <= lim) begin
         e.kind = k;
         e.cyc  = c;
         e.bc   = bc;
         q.push_back(e);
      end
   endtask

   // Called in the cycle where rx_in goes low (cycle t); returns in cycle
   // t+last+1 (the pulse cycle) or right after an abort reset.
   task automatic send(input logic [7:0] d, input int p, input bit pe,
                       input bit perr, input bit serr, input bit glitch,
                       input int abort);
      int t;
      int last;
      int lim;
      t    = cyc;
      last = glitch ? p : (10 + int'(pe)) * p;
      lim  = (abort != 0) ? t + abort : t + 100000;
      prescale    = 6'(p);
      rx_in       = 1'b0;
      par_en      = !pe;
      strt_glitch = 1'b0;
      par_err     = 1'b0;
      stp_err     = 1'b0;
      push(0, t + p, 0, lim);
      if (!glitch) begin
         for (int k = 0; k < 8; k++) push(1, t + (2 + k) * p, k + 1, lim);
         if (pe) push(2, t + 10 * p, 9, lim);
         push(3, t + last, 9 + int'(pe), lim);
         push(((pe && perr) || serr) ? 5 : 4, t + last + 1, 0, lim);
      end
      for (int r = 1; r <= last; r++) begin
         @(posedge clck);
         #1;
         if (abort != 0 && r == abort) begin
            rst = 1'b1;
            @(posedge clck);
            #1;
            rst         = 1'b0;
            rx_in       = 1'b1;
            strt_glitch = 1'b0;
            par_err     = 1'b0;
            stp_err     = 1'b0;
            return;
         end
         prescale = (r >= 2) ? ((p == 8) ? 6'd16 : 6'd8) : 6'(p);
         if (r <= p)          rx_in = 1'b0;
         else if (r <= 9 * p) rx_in = d[(r - p - 1) / p];
         else if (pe && r <= 10 * p) rx_in = ^d;
         else                 rx_in = 1'b1;
         par_en      = (r >= 9 * p - 1 && r <= 9 * p + 1) ? pe : !pe;
         strt_glitch = glitch && r == p;
         par_err     = perr && r == 10 * p;
         stp_err     = serr && r == last;
      end
      @(posedge clck);
      #1;
      rx_in       = 1'b1;
      strt_glitch = 1'b0;
      par_err     = 1'b0;
      stp_err     = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
         @(posedge clck);
         #1;
         n++;
      end
      repeat (4) @(posedge clck);
      #1;
      direct("drain_pending", q.size(), 0);
      q.delete();
   endtask

   task automatic idle_check(input string tag);
      @(negedge clck);
      direct({tag, "_edge_cnt"}, int'(edge_cnt), 0);
      direct({tag, "_bit_cnt"}, int'(bit_cnt), 0);
      direct({tag, "_samp_en"}, int'(data_samp_en), 0);
      direct({tag, "_dv"}, int'(data_valid), 0);
      direct({tag, "_fe"}, int'(frame_err), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst         = 1'b1;
      rx_in       = 1'b1;
      prescale    = 6'd8;
      par_en      = 1'b0;
      strt_glitch = 1'b0;
      par_err     = 1'b0;
      stp_err     = 1'b0;
      repeat (3) @(posedge clck);
      #1;
      idle_check("reset");
      rst = 1'b0;
      repeat (2) @(posedge clck);
      #1;

      send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      drain();
      send(8'h5A, 16, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      drain();
      send(8'hC3, 8, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      drain();
      send(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      idle_check("glitch");
      drain();
      send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 35);
      idle_check("abort");
      drain();
      send(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      drain();
      send(8'h0F, 32, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      drain();
      dv_cyc.delete();
      send(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      drain();
      tests++;
      if (dv_cyc.size() != 2) begin
         fails++;
         $display("FAIL b2b_pulses got %0d data_valid pulses, required 2", dv_cyc.size());
      end else if (dv_cyc[1] - dv_cyc[0] != 81) begin
         fails++;
         $display("FAIL b2b_gap got %0d, required 81", dv_cyc[1] - dv_cyc[0]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
